// File: rtl/cordic_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cordic_arbiter_if
// Description : Requester and CORDIC-side signal bundle for cordic_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface cordic_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_i;
    logic             req1_i;
    logic [WIDTH-1:0] angle0_i;
    logic [WIDTH-1:0] angle1_i;
    logic             sine_cosine0_i;
    logic             sine_cosine1_i;
    logic             gnt0_o;
    logic             gnt1_o;
    logic [WIDTH-1:0] result0_o;
    logic [WIDTH-1:0] result1_o;
    logic             valid0_o;
    logic             valid1_o;
    logic             err0_o;
    logic             err1_o;
    logic [WIDTH-1:0] cordic_angle_o;
    logic             cordic_sine_cosine_o;
    logic             cordic_start_o;
    logic [WIDTH-1:0] cordic_result_i;
    logic             cordic_busy_i;
    logic             cordic_valid_i;
    logic             busy_o;

    // Arbiter side
    modport slave (
        input  req0_i, req1_i, angle0_i, angle1_i, sine_cosine0_i, sine_cosine1_i,
        input  cordic_result_i, cordic_busy_i, cordic_valid_i,
        output gnt0_o, gnt1_o, result0_o, result1_o, valid0_o, valid1_o,
        output err0_o, err1_o, cordic_angle_o, cordic_sine_cosine_o,
        output cordic_start_o, busy_o
    );

    // Requester / CORDIC model side
    modport master (
        output req0_i, req1_i, angle0_i, angle1_i, sine_cosine0_i, sine_cosine1_i,
        output cordic_result_i, cordic_busy_i, cordic_valid_i,
        input  gnt0_o, gnt1_o, result0_o, result1_o, valid0_o, valid1_o,
        input  err0_o, err1_o, cordic_angle_o, cordic_sine_cosine_o,
        input  cordic_start_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/cordic_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cordic_arbiter
// Description : Round-robin sharing of one CORDIC core between two requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  wire logic      clk_i,
    input  wire logic      reset_i,
    cordic_arbiter_if.slave bus
);

    localparam int                 c_CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_owner;
    logic               r_last;
    logic [WIDTH-1:0]   r_angle;
    logic               r_sc;
    logic [WIDTH-1:0]   r_res0;
    logic [WIDTH-1:0]   r_res1;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_req_any;
    logic w_pick;
    logic w_grant;
    logic w_timeout;
    logic w_gnt0, w_gnt1, w_valid0, w_valid1, w_err0, w_err1, w_start;

    // On a tie the requester that was not served last wins.
    assign w_req_any = bus.req0_i | bus.req1_i;
    assign w_pick    = (bus.req0_i & bus.req1_i) ? ~r_last : bus.req1_i;
    assign w_grant   = !reset_i && (r_state == S_IDLE) && !bus.cordic_busy_i && w_req_any;
    assign w_timeout = (r_state == S_WAIT) && !bus.cordic_valid_i && (r_cnt == c_CNT_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_valid0    = 1'b0;
        w_valid1    = 1'b0;
        w_err0      = 1'b0;
        w_err1      = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = S_START;
                    w_gnt0      = ~w_pick;
                    w_gnt1      = w_pick;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
                w_start     = !reset_i;
            end
            S_WAIT: begin
                if (bus.cordic_valid_i) begin
                    w_state_nxt = S_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_err0      = !reset_i && !r_owner;
                    w_err1      = !reset_i && r_owner;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_valid0    = !reset_i && !r_owner;
                w_valid1    = !reset_i && r_owner;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_angle <= '0;
            r_sc    <= 1'b0;
            r_res0  <= '0;
            r_res1  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner <= w_pick;
                r_angle <= w_pick ? bus.angle1_i : bus.angle0_i;
                r_sc    <= w_pick ? bus.sine_cosine1_i : bus.sine_cosine0_i;
            end
            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if ((r_state == S_WAIT) && !bus.cordic_valid_i && !w_timeout) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == S_WAIT) && bus.cordic_valid_i) begin
                if (r_owner) r_res1 <= bus.cordic_result_i;
                else         r_res0 <= bus.cordic_result_i;
            end
            if ((r_state == S_DONE) || w_timeout) begin
                r_last <= r_owner;
            end
        end
    end

    assign bus.gnt0_o               = w_gnt0;
    assign bus.gnt1_o               = w_gnt1;
    assign bus.valid0_o             = w_valid0;
    assign bus.valid1_o             = w_valid1;
    assign bus.err0_o               = w_err0;
    assign bus.err1_o               = w_err1;
    assign bus.cordic_start_o       = w_start;
    assign bus.result0_o            = r_res0;
    assign bus.result1_o            = r_res1;
    assign bus.cordic_angle_o       = r_angle;
    assign bus.cordic_sine_cosine_o = r_sc;
    assign bus.busy_o               = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, 32, operand/result width.
- TIMEOUT, 64, maximum cycles waited for cordic valid.
REQ-002 The block SHALL have these ports (clock and reset first):
- clk_i  in  1  single clock; all logic rising-edge.
- reset_i  in  1  synchronous, active-high reset.
- req0_i / req1_i  in  1  requester n asks for a computation (level).
- angle0_i / angle1_i  in  WIDTH  requester n angle operand.
- sine_cosine0_i / sine_cosine1_i  in  1  requester n function select.
- gnt0_o / gnt1_o  out  1  one-cycle pulse: operands of requester n captured.
- result0_o / result1_o  out  WIDTH  last result delivered to requester n.
- valid0_o / valid1_o  out  1  one-cycle pulse: resultn_o is new.
- err0_o / err1_o  out  1  one-cycle pulse: requester n job timed out.
- cordic_angle_o  out  WIDTH  to cordic angle_i.
- cordic_sine_cosine_o  out  1  to cordic sine_cosine_i.
- cordic_start_o  out  1  to cordic start_i.
- cordic_result_i  in  WIDTH  from cordic result_o.
- cordic_busy_i  in  1  from cordic busy_o.
- cordic_valid_i  in  1  from cordic valid_o; cordic_result_i is valid in the same cycle.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-003 The FSM SHALL have four states: IDLE, START, WAIT, DONE.
REQ-004 In IDLE, when cordic_busy_i=0 and at least one reqn_i=1, the block SHALL select one requester, register its angle and sine_cosine, pulse gntn_o in that cycle, and move to START.
REQ-005 If only one request is present, that requester SHALL win.
REQ-006 If both requests are present, the requester not recorded in last_served SHALL win (round-robin).
REQ-007 In IDLE with cordic_busy_i=1, the block SHALL issue no grant and SHALL stay in IDLE.
REQ-008 START SHALL last exactly one cycle:
- cordic_start_o=1;
- cordic_angle_o and cordic_sine_cosine_o driven from the registered operands;
- timeout counter cleared to 0;
- next state WAIT.
REQ-009 cordic_angle_o and cordic_sine_cosine_o SHALL hold the registered operands stable from START until the FSM leaves WAIT.
REQ-010 In WAIT, on cordic_valid_i=1, the block SHALL load cordic_result_i into resultn_o of the granted requester and move to DONE.
REQ-011 In WAIT without cordic_valid_i, the counter SHALL increment each cycle.
REQ-012 When the counter reaches TIMEOUT-1 with no valid, the block SHALL pulse errn_o for one cycle, leave resultn_o unchanged, and return to IDLE.
REQ-013 If cordic_valid_i arrives in the same cycle the counter reaches TIMEOUT-1, the valid SHALL win and no error SHALL be raised.
REQ-014 DONE SHALL last exactly one cycle: validn_o=1, last_served set to the granted requester, next state IDLE.
REQ-015 After a timeout, last_served SHALL also be set to the granted requester.
REQ-016 resultn_o SHALL hold its value until the next successful completion for that requester; the other requester's result SHALL never change.
REQ-017 Latency:
- grant at cycle G;
- cordic_start_o at cycle G+1;
- cordic_valid_i at cycle V;
- validn_o at cycle V+1.
REQ-018 A reqn_i still high in the IDLE cycle after DONE or timeout SHALL be treated as a new request.
REQ-019 cordic_valid_i outside WAIT SHALL be ignored.
REQ-020 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-021 While reset_i=1 at a clock edge, the block SHALL enter IDLE with last_served=1, counter=0, and all outputs 0 (results, grants, valids, errors, cordic_* outputs, busy_o).
REQ-022 Reset asserted mid-operation (START, WAIT or DONE) SHALL abort the job at the next edge with no validn_o or errn_o pulse.
REQ-023 On the first cycle after reset deasserts, the block SHALL be able to grant.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Single request: req0=1, angle0=0x20000000, sc0=1, cordic valid 20 cycles after start -> gnt0 pulse at G, cordic_start at G+1, valid0 pulse at V+1, result0 equals cordic_result_i, result1 stays 0.
- Tie after reset: req0=req1=1 held -> grant order 0,1,0,1 over four jobs; each requester sees its own operands on cordic_angle_o.
- cordic_busy_i=1 with req1=1 -> no gnt1 while busy; gnt1 in the first cycle busy drops.
- Timeout (TIMEOUT=64), cordic never asserts valid -> err0 pulse exactly 64 cycles after start, FSM in IDLE, result0 unchanged, next tie goes to requester 1.
- Valid on the final timeout cycle -> valid0 pulse and no err0.
- reset_i pulsed for one cycle during WAIT -> all outputs 0, no valid or err pulse; a new req0 is granted on the cycle after reset drops.
